bird_motion_ctrl: RTL and testbench
===================================

Name: bird_motion_ctrl

Overview:
- Per-frame game/physics controller that drives the bird vertical position `y` consumed by vga640x480.
- Samples vga640x480's vsync. On each frame start it advances gravity and flap physics, and runs the IDLE/PLAY/DEAD game state machine.
- Sits between the debounced button logic and the VGA renderer, in the dclk domain.

Parameters:
- START_Y, 240: bird y at reset and in IDLE (active-area rows).
- FLOOR_Y, 460: max legal bird y (480 − 20 px sprite); reaching it = death.
- GRAVITY, 1: velocity increment per frame.
- FLAP_VEL, 8: upward speed applied on flap (velocity set to −FLAP_VEL).
- MAX_FALL, 10: downward velocity clamp.
- DEAD_FRAMES, 60: frames held in DEAD before a flap is accepted.

Ports:
- dclk  in  1  pixel clock, 25 MHz.
- clr  in  1  asynchronous reset, active-high.
- vsync  in  1  active-low vsync from vga640x480.
- flap  in  1  debounced button level, synchronous to dclk.
- y  out  10  bird row offset into the active area (unsigned), to vga640x480.
- state  out  2  game state: IDLE=0, PLAY=1, DEAD=2.
- frame_tick  out  1  one-cycle pulse, asserted in the cycle the new y is visible.
- dead_pulse  out  1  one-cycle pulse on PLAY→DEAD.

Behaviour:
- Interface: one clock (dclk); reset clr is asynchronous and active-high.
- Reset values: y=START_Y, state=IDLE, frame_tick=0, dead_pulse=0, vel=0, flap_pend=0, dead_cnt=0, vsync_q=1, flap_q=0.
- Frame event:
  - tick_c = vsync_q & ~vsync (vsync falling edge); vsync_q is vsync delayed one dclk.
  - All physics/state registers update on the edge where tick_c=1.
  - frame_tick = registered tick_c, so y and state change in the same cycle frame_tick=1. Latency is one dclk from the first sampled vsync low.
- Flap capture:
  - flap_c = flap & ~flap_q.
  - flap_c sets flap_pend. flap_pend clears on every tick.
  - A flap_c in the same cycle as tick_c counts for that tick.
  - Multiple edges per frame collapse to one.
- Velocity:
  - vel is an 8-bit signed register.
  - Sum computed in 12-bit signed: y_n = {0,y} + sext(vel_n).
- IDLE:
  - y=START_Y, vel=0.
  - On tick with flap_pend: state→PLAY, vel=−FLAP_VEL, y=START_Y−FLAP_VEL.
- PLAY, on each tick:
  - vel_n = flap_pend ? −FLAP_VEL : min(vel+GRAVITY, MAX_FALL).
  - y_n = y + vel_n.
  - If y_n < 0: y=0, vel=0 (ceiling clamp, no death).
  - If y_n ≥ FLOOR_Y: y=FLOOR_Y, vel=0, state→DEAD, dead_cnt=DEAD_FRAMES, dead_pulse=1 for one cycle (coincident with frame_tick).
  - Otherwise y=y_n, vel=vel_n.
- DEAD:
  - y and vel held.
  - On each tick with dead_cnt>0: dead_cnt decrements.
  - On a tick with dead_cnt==0 and flap_pend: state→IDLE, y=START_Y, vel=0.
  - Flaps while dead_cnt>0 are discarded at the tick.
- No ticks, i.e. vsync stuck: all state holds indefinitely.
- clr asserted mid-frame or mid-DEAD: immediate return to reset values. The first tick after release behaves as from IDLE.
- state encoding 3 is unreachable; if decoded, treat as IDLE on the next tick.

Optional Feature:
- Macro: BIRD_HOVER_EN.
- Defined:
  - In IDLE, each tick steps a 3-bit triangle counter.
  - y = START_Y − 4 + tri (range START_Y−4..START_Y+3, period 16 frames) to show a bobbing bird.
  - The counter resets to 0 on clr and on entry to IDLE.
  - On PLAY entry, physics starts from the current hover y rather than START_Y.
- Undefined: IDLE holds y=START_Y exactly. No counter is synthesized.

Decomposition:
- Shared package flappy_pkg:
  - game state localparams (ST_IDLE, ST_PLAY, ST_DEAD)
  - screen constants (ACTIVE_W=640, ACTIVE_H=480, BIRD_SIZE=20)
  - default physics constants
- Sub-module edge_rise (dclk, clr, level in, one-cycle pulse out, configurable reset value of the delay flop), instantiated twice:
  - on ~vsync, reset 0;
  - on flap, reset 0.

Test Plan:
- Reset and idle: clr pulse, then 3 frames with no flap → y=240, state=0, frame_tick pulses once per frame (every 800×521 dclk).
- Start and gravity: flap during frame 0 → tick 1: state=1, y=232; following ticks y=225, 219, 214 (vel −7, −6, −5).
- Terminal velocity: fall without flaps from y=240 → vel saturates at 10. Check that y steps by exactly 10 per frame after saturation.
- Floor death: fall until y_n ≥ 460 → y=460, state=2, dead_pulse high for exactly one cycle. Flap at dead_cnt=30 is ignored. Flap after 60 ticks → state=0, y=240.
- Ceiling clamp and simultaneity: flap every frame from y=10 → y clamps to 0, vel=0, state stays 1. A flap edge coincident with a vsync falling edge is applied on that tick.
- Async reset mid-PLAY: assert clr between dclk edges at y=300 → outputs immediately show reset values. After release the next tick with flap_pend starts PLAY from 240.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared game constants for the flappy-bird datapath: state encoding, screen
// geometry and the default physics tuning used by bird_motion_ctrl.
package flappy_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StPlay = ST_PLAY,
        StDead = ST_DEAD,
        StRsvd = 2'd3
    } game_state_e;

    localparam int unsigned ACTIVE_W  = 640;
    localparam int unsigned ACTIVE_H  = 480;
    localparam int unsigned BIRD_SIZE = 20;

    localparam int unsigned DEF_START_Y     = 240;
    localparam int unsigned DEF_FLOOR_Y     = ACTIVE_H - BIRD_SIZE;
    localparam int unsigned DEF_GRAVITY     = 1;
    localparam int unsigned DEF_FLAP_VEL    = 8;
    localparam int unsigned DEF_MAX_FALL    = 10;
    localparam int unsigned DEF_DEAD_FRAMES = 60;

    // Velocity is 8-bit signed; position arithmetic is done 12-bit signed.
    function automatic logic signed [11:0] sext_vel(input logic signed [7:0] v);
        return {{4{v[7]}}, v};
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one-cycle combinational pulse when level goes 0->1.
// RESET_VAL sets the delay flop's value while clr is asserted.
module edge_rise #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic dclk,
    input  logic clr,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            level_q <= RESET_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/bird_motion_ctrl.sv
// Per-frame bird physics and IDLE/PLAY/DEAD game FSM, advanced on vsync fall.
// Optional idle bobbing animation enabled by defining BIRD_HOVER_EN.
module bird_motion_ctrl
    import flappy_pkg::*;
#(
    parameter int unsigned START_Y     = DEF_START_Y,
    parameter int unsigned FLOOR_Y     = DEF_FLOOR_Y,
    parameter int unsigned GRAVITY     = DEF_GRAVITY,
    parameter int unsigned FLAP_VEL    = DEF_FLAP_VEL,
    parameter int unsigned MAX_FALL    = DEF_MAX_FALL,
    parameter int unsigned DEAD_FRAMES = DEF_DEAD_FRAMES
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       vsync,
    input  logic       flap,
    output logic [9:0] y,
    output logic [1:0] state,
    output logic       frame_tick,
    output logic       dead_pulse
);

    localparam int unsigned CntW = $clog2(DEAD_FRAMES + 1);

    localparam logic [9:0]        YStart   = 10'(START_Y);
    localparam logic [9:0]        YFloor   = 10'(FLOOR_Y);
    localparam logic signed [11:0] YFloorS = 12'(FLOOR_Y);
    localparam logic [9:0]        YFlap    = 10'(FLAP_VEL);
    localparam logic signed [7:0] VelFlap  = 8'(32'd0 - FLAP_VEL);
    localparam logic signed [7:0] VelGrav  = 8'(GRAVITY);
    localparam logic signed [7:0] VelMax   = 8'(MAX_FALL);
    localparam logic [CntW-1:0]   DeadInit = CntW'(DEAD_FRAMES);

    logic tick_c;
    logic flap_c;

    // Delay flop on ~vsync resets to 0, i.e. vsync is assumed high out of reset.
    edge_rise #(
        .RESET_VAL (1'b0)
    ) u_vsync_fall (
        .dclk  (dclk),
        .clr   (clr),
        .level (~vsync),
        .pulse (tick_c)
    );

    edge_rise #(
        .RESET_VAL (1'b0)
    ) u_flap_rise (
        .dclk  (dclk),
        .clr   (clr),
        .level (flap),
        .pulse (flap_c)
    );

    logic [9:0]        y_q, y_d;
    logic signed [7:0] vel_q, vel_d;
    game_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              frame_tick_q, frame_tick_d;
    logic              dead_pulse_q, dead_pulse_d;

    logic              pend;
    logic signed [7:0] vel_inc;
    logic signed [7:0] vel_n;
    logic signed [11:0] y_sum;
    logic [9:0]        idle_base;

`ifdef BIRD_HOVER_EN
    logic [3:0] phase_q, phase_d;

    // 16-phase counter folded into a 0..7..0 triangle.
    function automatic logic [2:0] tri_of(input logic [3:0] ph);
        return ph[3] ? ~ph[2:0] : ph[2:0];
    endfunction

    assign idle_base = y_q;
`else
    assign idle_base = YStart;
`endif

    always_comb begin
        pend         = pend_q | flap_c;
        pend_d       = tick_c ? 1'b0 : pend;
        y_d          = y_q;
        vel_d        = vel_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_tick_d = tick_c;
        dead_pulse_d = 1'b0;
`ifdef BIRD_HOVER_EN
        phase_d      = phase_q;
`endif

        vel_inc = vel_q + VelGrav;
        vel_n   = pend ? VelFlap : ((vel_inc > VelMax) ? VelMax : vel_inc);
        y_sum   = $signed({2'b00, y_q}) + sext_vel(vel_n);

        if (tick_c) begin
            unique case (state_q)
                StPlay: begin
                    if (y_sum < 12'sd0) begin
                        y_d   = '0;
                        vel_d = '0;
                    end else if (y_sum >= YFloorS) begin
                        y_d          = YFloor;
                        vel_d        = '0;
                        state_d      = StDead;
                        cnt_d        = DeadInit;
                        dead_pulse_d = 1'b1;
                    end else begin
                        y_d   = y_sum[9:0];
                        vel_d = vel_n;
                    end
                end
                StDead: begin
                    // Flaps seen while counting down are dropped with pend at this tick.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else if (pend) begin
                        state_d = StIdle;
                        y_d     = YStart;
                        vel_d   = '0;
`ifdef BIRD_HOVER_EN
                        phase_d = '0;
`endif
                    end
                end
                default: begin
                    // StIdle, and the unreachable encoding recovers as idle.
                    if (pend) begin
                        state_d = StPlay;
                        vel_d   = VelFlap;
                        y_d     = idle_base - YFlap;
                    end else begin
                        state_d = StIdle;
                        vel_d   = '0;
`ifdef BIRD_HOVER_EN
                        phase_d = phase_q + 4'd1;
                        y_d     = YStart - 10'd4 + {7'd0, tri_of(phase_d)};
`else
                        y_d     = YStart;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            y_q          <= YStart;
            vel_q        <= '0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            dead_pulse_q <= 1'b0;
`ifdef BIRD_HOVER_EN
            phase_q      <= '0;
`endif
        end else begin
            y_q          <= y_d;
            vel_q        <= vel_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            frame_tick_q <= frame_tick_d;
            dead_pulse_q <= dead_pulse_d;
`ifdef BIRD_HOVER_EN
            phase_q      <= phase_d;
`endif
        end
    end

    assign y          = y_q;
    assign state      = state_q;
    assign frame_tick = frame_tick_q;
    assign dead_pulse = dead_pulse_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Scoreboard bench for bird_motion_ctrl using short synthetic frames: an
// integer model pushes expected y/state/dead_pulse per vsync fall, a monitor pops on frame_tick.
module tb_bird_motion_ctrl;

    logic       dclk = 1'b0;
    logic       clr;
    logic       vsync;
    logic       flap;
    logic [9:0] y;
    logic [1:0] state;
    logic       frame_tick;
    logic       dead_pulse;

    bird_motion_ctrl dut (
        .dclk       (dclk),
        .clr        (clr),
        .vsync      (vsync),
        .flap       (flap),
        .y          (y),
        .state      (state),
        .frame_tick (frame_tick),
        .dead_pulse (dead_pulse)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        int y;
        int st;
        int dp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model of the game physics.
    int m_y, m_vel, m_st, m_cnt;

    task automatic model_reset();
        m_y   = 240;
        m_vel = 0;
        m_st  = 0;
        m_cnt = 0;
    endtask

    task automatic model_tick(input bit pend);
        exp_t e;
        int   vn, yn;
        e.dp = 0;
        case (m_st)
            1: begin
                vn = pend ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
                yn = m_y + vn;
                if (yn < 0) begin
                    m_y = 0; m_vel = 0;
                end else if (yn >= 460) begin
                    m_y = 460; m_vel = 0; m_st = 2; m_cnt = 60; e.dp = 1;
                end else begin
                    m_y = yn; m_vel = vn;
                end
            end
            2: begin
                if (m_cnt > 0) m_cnt--;
                else if (pend) begin
                    m_st = 0; m_y = 240; m_vel = 0;
                end
            end
            default: begin
                if (pend) begin
                    m_st = 1; m_vel = -8; m_y = 232;
                end
            end
        endcase
        e.y  = m_y;
        e.st = m_st;
        sb_q.push_back(e);
    endtask

    // One short frame: 'presses' flap pulses while vsync is high, optional flap
    // edge in the exact cycle vsync falls, then vsync low for 3 cycles.
    task automatic frame(input int presses, input bit coincide);
        bit pend;
        pend  = (presses > 0) || coincide;
        vsync = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge dclk); #1;
            flap = (c % 2 == 1) && (c < 2 * presses);
        end
        @(posedge dclk); #1;
        vsync = 1'b0;
        flap  = coincide;
        model_tick(pend);
        @(posedge dclk); #1;
        flap = 1'b0;
        repeat (2) @(posedge dclk);
        #1;
    endtask

    always @(negedge dclk) begin
        if (!clr) begin
            if (frame_tick) begin
                if (sb_q.size() == 0) begin
                    check("spurious_tick", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("tick_y", int'(y), mon_e.y);
                    check("tick_state", int'(state), mon_e.st);
                    check("tick_dead_pulse", int'(dead_pulse), mon_e.dp);
                end
            end else if (dead_pulse) begin
                check("dead_pulse_without_tick", 1, 0);
            end
        end
    end

    int prev_y;
    int prev_vel;
    int guard;

    initial begin
        clr   = 1'b1;
        vsync = 1'b1;
        flap  = 1'b0;
        model_reset();
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        check("rst_y", int'(y), 240);
        check("rst_state", int'(state), 0);
        check("rst_frame_tick", int'(frame_tick), 0);
        check("rst_dead_pulse", int'(dead_pulse), 0);
        @(posedge dclk); #1;
        clr = 1'b0;

        // Idle frames, then start with a double press (collapses to one flap).
        repeat (3) frame(0, 0);
        frame(2, 0);
        check("start_y", int'(y), 232);

        // Free fall to the floor; check terminal-velocity step.
        guard = 0;
        while (m_st == 1 && guard < 100) begin
            prev_y   = int'(y);
            prev_vel = m_vel;
            frame(0, 0);
            if (m_st == 1 && prev_vel == 10) check("terminal_step", int'(y) - prev_y, 10);
            guard++;
        end
        check("floor_state", int'(state), 2);
        check("floor_y", int'(y), 460);

        // Dead hold: flaps every 10 ticks are dropped until the counter runs out.
        for (int i = 0; i <= 60; i++) begin
            frame((i % 10 == 0) ? 1 : 0, 0);
            if (i == 30) check("dead_ignore_flap", int'(state), 2);
        end
        check("revive_state", int'(state), 0);
        check("revive_y", int'(y), 240);

        // Flap every frame up into the ceiling, some edges coincident with vsync.
        for (int i = 0; i < 34; i++) begin
            if (i % 4 == 3) frame(0, 1);
            else frame(1, 0);
        end
        check("ceiling_y", int'(y), 0);
        check("ceiling_state", int'(state), 1);

        // Stuck vsync: nothing may change.
        vsync = 1'b1;
        repeat (400) @(posedge dclk);
        #1;
        check("stuck_y", int'(y), m_y);
        check("stuck_state", int'(state), m_st);

        // A few falling frames, then async reset between clock edges.
        repeat (3) frame(0, 0);
        @(posedge dclk); #3;
        clr = 1'b1;
        #1;
        check("async_y", int'(y), 240);
        check("async_state", int'(state), 0);
        check("async_frame_tick", int'(frame_tick), 0);
        check("async_dead_pulse", int'(dead_pulse), 0);
        model_reset();
        @(posedge dclk); #1;
        clr = 1'b0;
        frame(0, 0);
        frame(0, 1);
        check("restart_y", int'(y), 232);

        repeat (4) @(posedge dclk);
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
